// File: rtl/cnn_pkg.sv
// Shared constants and types for the binary CNN datapath.
// Used by the image loader, conv_layer and the downstream layers.
package cnn_pkg;

  localparam int IMG_W      = 28;
  localparam int IMG_H      = 28;
  localparam int N_PIX      = 784;
  localparam int PIX_W      = 8;
  localparam int BIN_THRESH = 128;
  localparam int KSIZE      = 5;
  localparam int CONV_W     = 24;

  typedef enum logic {
    LOAD = 1'b0,
    DONE = 1'b1
  } ld_state_t;

endpackage

// File: rtl/pixel_binarizer.sv
// Combinational unsigned threshold compare of one grayscale pixel.
// Output is 1 when the pixel is at or above THRESH.
module pixel_binarizer #(
  parameter int PIX_W  = 8,
  parameter int THRESH = 128
) (
  input  logic [PIX_W-1:0] pix,
  output logic             bin
);

  localparam logic [PIX_W-1:0] TH = PIX_W'(THRESH);

  assign bin = (pix >= TH);

endmodule

// File: rtl/input_image_loader.sv
// Streams row-major grayscale pixels in, binarises them and assembles
// the flat input_node vector for conv_layer.
module input_image_loader #(
  parameter int IMG_W  = cnn_pkg::IMG_W,
  parameter int IMG_H  = cnn_pkg::IMG_H,
  parameter int PIX_W  = cnn_pkg::PIX_W,
  parameter int THRESH = cnn_pkg::BIN_THRESH
) (
  input  logic                   CLK,
  input  logic                   NRST,
  input  logic                   next,
  input  logic                   in_valid,
  input  logic                   in_sof,
  input  logic [PIX_W-1:0]       in_data,
  output logic                   in_ready,
  output logic [IMG_W*IMG_H-1:0] input_node,
  output logic                   input_finish,
  output logic [9:0]             pix_count,
  output logic                   err_sync
);

  import cnn_pkg::*;

  localparam int N = IMG_W * IMG_H;
  localparam logic [9:0] LAST = 10'(N - 1);
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  ld_state_t      state_q, state_d;
  logic [9:0]     cnt_q, cnt_d;
  logic [N-1:0]   node_q, node_d;
  logic           fin_q, fin_d;
  logic           err_q, err_d;
  logic [9:0]     wr_idx;
  logic [N-1:0]   wr_sel;
  logic           accept;
  logic           resync;
  logic           pix_bin;

  pixel_binarizer #(
    .PIX_W  (PIX_W),
    .THRESH (THRESH)
  ) u_bin (
    .pix (in_data),
    .bin (pix_bin)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    node_d   = node_q;
    fin_d    = fin_q;
    err_d    = err_q;
    in_ready = 1'b0;
    wr_idx   = cnt_q;
    wr_sel   = '0;
    resync   = 1'b0;
    unique case (state_q)
      LOAD: in_ready = NRST & ~next;
      DONE: in_ready = 1'b0;
      default: in_ready = 1'b0;
    endcase
    accept = in_valid & in_ready;
    if (accept) begin
      // A start-of-frame mid-stream restarts the write pointer at bit 0.
      resync = in_sof & (cnt_q != 10'd0);
      wr_idx = resync ? 10'd0 : cnt_q;
      wr_sel = ONE << wr_idx;
      node_d = (node_q & ~wr_sel) | ({N{pix_bin}} & wr_sel);
      cnt_d  = wr_idx + 10'd1;
      if (resync) err_d = 1'b1;
      if (wr_idx == LAST) begin
        state_d = DONE;
        fin_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!NRST || next) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      node_q  <= '0;
      fin_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      node_q  <= node_d;
      fin_q   <= fin_d;
      err_q   <= err_d;
    end
  end

  assign input_node   = node_q;
  assign input_finish = fin_q;
  assign pix_count    = cnt_q;
  assign err_sync     = err_q;

endmodule
